// File: rtl/sockit_spi_arb.sv
// Round-robin, packet-locked arbiter for the shared SPI command channel, with a registered output.
// Optional lock timeout with err pulse: define SOCKIT_SPI_ARB_TIMEOUT_EN.
module sockit_spi_arb #(
   parameter int N   = 3,
   parameter int DW  = 32,
   parameter int LST = 31,
   parameter int TMO = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic [N-1:0]    req_vld,
   input  logic [N*DW-1:0] req_dat,
   output logic [N-1:0]    req_rdy,
   output logic            cmd_vld,
   output logic [DW-1:0]   cmd_dat,
   input  logic            cmd_rdy,
   output logic [N-1:0]    gnt,
`ifdef SOCKIT_SPI_ARB_TIMEOUT_EN
   output logic            err,
`endif
   output logic            busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ptr, owner, sel_idx;
   logic [N-1:0]  sel;
   logic          acc, xfer, tmo_hit;
   logic [DW-1:0] dat;
   int            idx;
   logic          found;

   assign acc     = ~cmd_vld | cmd_rdy;
   assign req_rdy = sel & {N{acc}};
   assign xfer    = |(req_vld & req_rdy);
   assign dat     = req_dat[int'(sel_idx)*DW +: DW];
   assign gnt     = (state_q == LOCK) ? sel : '0;
   assign busy    = (state_q == LOCK) | cmd_vld;

   // Rotating search starts just after the last winner, so no requester has fixed priority.
   always_comb begin
      sel     = '0;
      sel_idx = '0;
      found   = 1'b0;
      idx     = 0;
      if (state_q == LOCK) begin
         sel[owner] = 1'b1;
         sel_idx    = owner;
      end else begin
         for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req_vld[idx]) begin
               found    = 1'b1;
               sel[idx] = 1'b1;
               sel_idx  = PW'(idx);
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (xfer && !dat[LST]) state_d = LOCK;
         LOCK:    if ((xfer && dat[LST]) || tmo_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr     <= PW'(N-1);
         owner   <= '0;
      end else if (clr) begin
         state_q <= IDLE;
         ptr     <= PW'(N-1);
         owner   <= '0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            ptr   <= sel_idx;
            owner <= sel_idx;
         end else if (tmo_hit) begin
            ptr <= owner;
         end
      end
   end

   // Output stage: one register toward the SPI sequencer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_vld <= 1'b0;
         cmd_dat <= '0;
      end else if (clr) begin
         cmd_vld <= 1'b0;
         cmd_dat <= '0;
      end else if (xfer) begin
         cmd_vld <= 1'b1;
         cmd_dat <= dat;
      end else if (cmd_rdy) begin
         cmd_vld <= 1'b0;
      end
   end

`ifdef SOCKIT_SPI_ARB_TIMEOUT_EN
   logic [7:0] cnt;

   // Fires on the idle cycle that would bring the count up to TMO.
   assign tmo_hit = (state_q == LOCK) && !xfer && !req_vld[owner] &&
                    ((cnt + 8'd1) == 8'(TMO));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         err <= tmo_hit;
         if (state_q != LOCK || xfer || tmo_hit)
            cnt <= '0;
         else if (!req_vld[owner])
            cnt <= cnt + 8'd1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Scoreboard bench for sockit_spi_arb: queued requester models feed the arbiter, expected beats are popped at the output.
module tb_sockit_spi_arb;

   localparam int N  = 3;
   localparam int DW = 32;
`ifdef SOCKIT_SPI_ARB_TIMEOUT_EN
   localparam int TB_TMO = 4;
`else
   localparam int TB_TMO = 255;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            clr = 1'b0;
   logic [N-1:0]    req_vld = '0;
   logic [N*DW-1:0] req_dat = '0;
   logic [N-1:0]    req_rdy;
   logic            cmd_vld;
   logic [DW-1:0]   cmd_dat;
   logic            cmd_rdy = 1'b1;
   logic [N-1:0]    gnt;
   logic            busy;
`ifdef SOCKIT_SPI_ARB_TIMEOUT_EN
   logic            err;
`endif

   sockit_spi_arb #(.N(N), .DW(DW), .LST(31), .TMO(TB_TMO)) dut (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .req_vld (req_vld),
      .req_dat (req_dat),
      .req_rdy (req_rdy),
      .cmd_vld (cmd_vld),
      .cmd_dat (cmd_dat),
      .cmd_rdy (cmd_rdy),
      .gnt     (gnt),
`ifdef SOCKIT_SPI_ARB_TIMEOUT_EN
      .err     (err),
`endif
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int          n_run  = 0;
   int          n_fail = 0;
   logic [31:0] src_q [N][$];
   logic [31:0] exp_q [$];
   logic [N-1:0] hs = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Mid-cycle monitor: record source handshakes and score delivered beats.
   always @(negedge clk) begin
      hs <= req_vld & req_rdy;
      if (cmd_vld && cmd_rdy) begin
         if (exp_q.size() == 0) chk("sb_extra", {31'd0, cmd_vld}, 32'd0);
         else                   chk("sb_dat", cmd_dat, exp_q.pop_front());
      end
   end

   task automatic present();
      for (int i = 0; i < N; i++) begin
         req_vld[i] = (src_q[i].size() != 0);
         req_dat[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      present();
      #1;
   endtask

   task automatic put(input int i, input logic [31:0] d);
      src_q[i].push_back(d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vld", {31'd0, cmd_vld}, 32'd0);
      chk("rst_gnt", {29'd0, gnt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      cyc();

      // single beat
      put(0, 32'h8000_00A5); exp_q.push_back(32'h8000_00A5);
      present(); #1;
      chk("sb_rdy", {29'd0, req_rdy}, 32'd1);
      chk("sb_gnt0", {29'd0, gnt}, 32'd0);
      cyc();
      chk("sb_vld", {31'd0, cmd_vld}, 32'd1);
      chk("sb_out", cmd_dat, 32'h8000_00A5);
      chk("sb_gnt1", {29'd0, gnt}, 32'd0);
      cyc();

      // round robin from a cleared pointer
      clr = 1'b1; cyc(); clr = 1'b0;
      chk("clr_vld", {31'd0, cmd_vld}, 32'd0);
      for (int j = 0; j < 4; j++)
         for (int i = 0; i < N; i++) begin
            put(i, 32'h8000_0000 | (i << 4) | j);
            exp_q.push_back(32'h8000_0000 | (i << 4) | j);
         end
      present(); #1;
      for (int c = 0; c < 12; c++) begin
         cyc();
         chk("rr_vld", {31'd0, cmd_vld}, 32'd1);
      end
      cyc(); cyc();

      // packet lock: move pointer to 0 first
      put(0, 32'h8000_00B0); exp_q.push_back(32'h8000_00B0);
      present(); #1;
      cyc();
      put(1, 32'h0000_0011); put(1, 32'h0000_0012); put(1, 32'h8000_0013);
      put(0, 32'h8000_0020); put(2, 32'h8000_0022);
      exp_q.push_back(32'h0000_0011); exp_q.push_back(32'h0000_0012);
      exp_q.push_back(32'h8000_0013); exp_q.push_back(32'h8000_0022);
      exp_q.push_back(32'h8000_0020);
      present(); #1;
      chk("pk_rdy0", {29'd0, req_rdy}, 32'b010);
      chk("pk_gnt0", {29'd0, gnt}, 32'b000);
      for (int c = 0; c < 2; c++) begin
         cyc();
         chk("pk_gnt", {29'd0, gnt}, 32'b010);
         chk("pk_rdy", {29'd0, req_rdy}, 32'b010);
         chk("pk_busy", {31'd0, busy}, 32'd1);
      end
      cyc();
      chk("pk_next2", {29'd0, req_rdy}, 32'b100);
      chk("pk_idle", {29'd0, gnt}, 32'b000);
      cyc();
      chk("pk_next0", {29'd0, req_rdy}, 32'b001);
      cyc(); cyc(); cyc();

      // backpressure
      cmd_rdy = 1'b0;
      put(2, 32'h8000_0051); put(2, 32'h8000_0052);
      exp_q.push_back(32'h8000_0051); exp_q.push_back(32'h8000_0052);
      present(); #1;
      chk("bp_rdy0", {29'd0, req_rdy}, 32'b100);
      for (int c = 0; c < 5; c++) begin
         cyc();
         chk("bp_rdy", {29'd0, req_rdy}, 32'd0);
         chk("bp_dat", cmd_dat, 32'h8000_0051);
      end
      cmd_rdy = 1'b1; #1;
      chk("bp_rel", {29'd0, req_rdy}, 32'b100);
      cyc();
      chk("bp_next", cmd_dat, 32'h8000_0052);
      cyc(); cyc();

      // clear during lock with a held beat (0x61 is discarded)
      cmd_rdy = 1'b0;
      put(1, 32'h0000_0061); put(1, 32'h0000_0062); put(1, 32'h8000_0063);
      present(); #1;
      cyc();
      chk("cl_gnt", {29'd0, gnt}, 32'b010);
      chk("cl_busy", {31'd0, busy}, 32'd1);
      clr = 1'b1;
      put(0, 32'h8000_0070);
      present();
      cyc();
      clr = 1'b0; #1;
      chk("cl_vld", {31'd0, cmd_vld}, 32'd0);
      chk("cl_gnt0", {29'd0, gnt}, 32'd0);
      chk("cl_busy0", {31'd0, busy}, 32'd0);
      chk("cl_win0", {29'd0, req_rdy}, 32'b001);
      exp_q.push_back(32'h8000_0070); exp_q.push_back(32'h0000_0062);
      exp_q.push_back(32'h8000_0063);
      cmd_rdy = 1'b1;
      repeat (5) cyc();

      // asynchronous reset during lock with a held beat
      cmd_rdy = 1'b0;
      put(1, 32'h0000_0071); put(1, 32'h8000_0072);
      present(); #1;
      cyc();
      chk("rs_gnt", {29'd0, gnt}, 32'b010);
      #2;
      rst = 1'b0;
      for (int i = 0; i < N; i++) src_q[i].delete();
      present(); #1;
      chk("rs_vld", {31'd0, cmd_vld}, 32'd0);
      chk("rs_gnt0", {29'd0, gnt}, 32'd0);
      chk("rs_busy", {31'd0, busy}, 32'd0);
      cyc();
      rst = 1'b1;
      cmd_rdy = 1'b1;
      put(0, 32'h8000_0081); put(2, 32'h8000_0082);
      exp_q.push_back(32'h8000_0081); exp_q.push_back(32'h8000_0082);
      present(); #1;
      chk("rs_win0", {29'd0, req_rdy}, 32'b001);
      repeat (4) cyc();

`ifdef SOCKIT_SPI_ARB_TIMEOUT_EN
      // lock timeout: owner 0 stalls after a non-last beat
      put(0, 32'h0000_0091); put(1, 32'h8000_00A1);
      exp_q.push_back(32'h0000_0091); exp_q.push_back(32'h8000_00A1);
      present(); #1;
      cyc();
      for (int c = 0; c < 4; c++) begin
         chk("to_err0", {31'd0, err}, 32'd0);
         chk("to_gnt", {29'd0, gnt}, 32'b001);
         cyc();
      end
      chk("to_err1", {31'd0, err}, 32'd1);
      chk("to_gnt0", {29'd0, gnt}, 32'd0);
      chk("to_win1", {29'd0, req_rdy}, 32'b010);
      cyc();
      chk("to_pulse", {31'd0, err}, 32'd0);
      repeat (3) cyc();
`endif

      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/sockit_spi_arb.md
Name: sockit_spi_arb

Overview:
- N-way round-robin arbiter sharing the single SPI command channel between several requesters, e.g. CPU register port, XIP/boot reader and DMA.
- Each requester and the downstream command drain use the standard vld/rdy handshake; a transfer happens when vld & rdy.
- Multi-beat commands are packet-locked: ownership is held until a beat with the last flag set.
- Output is registered, giving one pipeline stage toward the SPI sequencer.

Parameters:
- N, 3: number of requesters, 2..8.
- DW, 32: command beat width, including the last flag.
- LST, 31: bit index of the last flag within a beat.
- TMO, 255: lock-timeout idle-cycle limit; used only with the optional feature; 8-bit counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous reset, active-low; asserted at rst==0.
- clr  input  1  synchronous clear, active-high.
- req_vld  input  N  per-requester valid.
- req_dat  input  N*DW  per-requester beat; requester i at [i*DW +: DW].
- req_rdy  output  N  per-requester ready.
- cmd_vld  output  1  downstream valid (registered).
- cmd_dat  output  DW  downstream beat (registered).
- cmd_rdy  input  1  downstream ready.
- gnt  output  N  one-hot current owner; all-zero when no owner.
- busy  output  1  lock held or output register occupied.
- err  output  1  lock-timeout pulse; present only with the optional feature.

Behaviour:
- Reset (rst==0, async) and clr (sync) force the same state:
  - FSM=IDLE, ptr=N-1, cmd_vld=0, cmd_dat=0, gnt=0, busy=0, err=0, timeout counter=0.
  - clr discards a beat held in the output register.
- Output register:
  - acc = ~cmd_vld | cmd_rdy.
  - On a requester transfer, the beat loads into cmd_dat and cmd_vld=1 the next cycle.
  - cmd_vld clears when cmd_rdy is high with no new load.
  - Latency from requester transfer to cmd_vld is 1 cycle.
  - Full throughput of 1 beat/cycle when cmd_rdy is held high.
- req_rdy[i] = acc & sel[i], where sel is a one-hot selection; combinational from cmd_rdy.
- FSM IDLE:
  - sel = first requester with req_vld set, searching from ptr+1 upward and wrapping at N-1 -> 0. Combinational, so a same-cycle grant is possible.
  - gnt = 0.
  - On transfer from requester k: ptr <= k.
  - If dat[LST]==0, go to LOCK with owner <= k. If dat[LST]==1 (single-beat command), stay in IDLE.
- FSM LOCK:
  - sel = gnt = one-hot(owner). Other requesters are never ready, even if the owner's vld is low.
  - A transfer with dat[LST]==1 returns the FSM to IDLE; the next arbitration starts after the owner.
- req_vld must remain stable until the transfer completes (source rule). The arbiter does not re-arbitrate while acc==0: sel is recomputed each cycle, but no grant is issued without a transfer.
- Simultaneous requesters: resolved purely by ptr rotation, with no fixed priority. With ptr=N-1, requester 0 wins.
- busy = (FSM==LOCK) | cmd_vld.
- clr during LOCK: owner and lock are dropped. The requester's remaining beats are then treated as new commands.

Optional Feature:
- Macro: SOCKIT_SPI_ARB_TIMEOUT_EN.
- Defined:
  - In LOCK, an 8-bit counter increments each cycle the owner's req_vld==0 and resets to 0 on any owner transfer.
  - When the counter reaches TMO: FSM goes to IDLE, ptr=owner, counter=0, and err pulses high for exactly 1 cycle.
  - Beats already in the output register are still delivered.
- Undefined:
  - No counter and no err port; the lock is held indefinitely.

Test Plan:
- Single beat: req_vld=001, dat=0x8000_00A5, cmd_rdy=1 -> req_rdy[0]=1 same cycle; next cycle cmd_vld=1, cmd_dat=0x8000_00A5; gnt stays 000.
- Round-robin: all three requesters send a continuous stream of last-flagged beats, cmd_rdy=1 -> output source order 0,1,2,0,1,2; one beat per cycle with no bubbles.
- Packet lock: requester 1 sends 0x0000_0011, 0x0000_0012, 0x8000_0013 while requesters 0 and 2 are valid -> gnt=010 through the packet; req_rdy[0]=req_rdy[2]=0; after the last beat, requester 2 is granted next.
- Backpressure: cmd_rdy=0 for 5 cycles with cmd_vld=1 -> all req_rdy=0 and cmd_dat stable; cmd_rdy=1 -> held beat consumed, next beat loads the same cycle.
- Reset/clear mid-packet: rst low (async) or clr=1 during LOCK with cmd_vld=1 -> cmd_vld=0, gnt=000, busy=0 immediately (rst) or next edge (clr); requester 0 wins next.
- Timeout (macro on, TMO=4): owner 0 stalls after a non-last beat -> after 4 idle cycles err=1 for 1 cycle and gnt=000; requester 1 is granted the following cycle.
